// File: rtl/video_timing_gen_pkg.sv
// video_timing_pkg: timing record, standard mode presets and the mode validity
// check shared by the generator and its bench.
package video_timing_pkg;
    localparam int CORDW_MAX = 12;
    typedef struct packed {
        logic [CORDW_MAX-1:0] h_active, h_fp, h_sync, h_bp;
        logic [CORDW_MAX-1:0] v_active, v_fp, v_sync, v_bp;
    } timing_t;
    localparam timing_t T_640X480P60 = '{12'd640, 12'd16, 12'd96, 12'd48, 12'd480, 12'd10, 12'd2, 12'd33};
    localparam timing_t T_720P60 = '{12'd1280, 12'd110, 12'd40, 12'd220, 12'd720, 12'd5, 12'd5, 12'd20};
    localparam timing_t T_1080P30 = '{12'd1920, 12'd88, 12'd44, 12'd148, 12'd1080, 12'd4, 12'd5, 12'd36};
    // Fields are taken modulo 2^cordw so a narrower generator judges what it will actually load.
    function automatic logic timing_ok(timing_t t, int cordw = CORDW_MAX);
        int m, ht, vt;
        m = (1 << cordw) - 1;
        ht = (int'(t.h_active) & m) + (int'(t.h_fp) & m) + (int'(t.h_sync) & m) + (int'(t.h_bp) & m);
        vt = (int'(t.v_active) & m) + (int'(t.v_fp) & m) + (int'(t.v_sync) & m) + (int'(t.v_bp) & m);
        return (int'(t.h_active) & m) != 0 && (int'(t.v_active) & m) != 0 &&
               (int'(t.h_sync) & m) != 0 && (int'(t.v_sync) & m) != 0 &&
               ht <= (1 << cordw) && vt <= (1 << cordw);
    endfunction
endpackage

// File: rtl/video_timing_gen_if.sv
// video_timing_gen_if: mode-update handshake plus the decoded raster outputs.
import video_timing_pkg::*;
interface video_timing_gen_if #(parameter int CORDW = 12);
    timing_t cfg;
    logic cfg_valid, cfg_ready, cfg_err;
    logic [CORDW-1:0] sx, sy;
    logic hsync, vsync, de, line_start, frame_start;
    modport master(output cfg, cfg_valid,
                   input cfg_ready, cfg_err, sx, sy, hsync, vsync, de, line_start, frame_start);
    modport slave(input cfg, cfg_valid,
                  output cfg_ready, cfg_err, sx, sy, hsync, vsync, de, line_start, frame_start);
endinterface

// File: rtl/video_timing_gen_timing_axis.sv
// timing_axis: one raster dimension -- position counter, boundary registers
// reloaded on apply, and raw (active-high) active/sync decode.
module timing_axis #(
    parameter int CORDW = 12,
    parameter logic [CORDW-1:0] I_ACT = 1,
    parameter logic [CORDW-1:0] I_FP = 0,
    parameter logic [CORDW-1:0] I_SYNC = 1,
    parameter logic [CORDW-1:0] I_BP = 0
) (
    input logic clk,
    input logic rst,
    input logic adv,
    input logic load,
    input logic [CORDW-1:0] act,
    input logic [CORDW-1:0] fp,
    input logic [CORDW-1:0] sync,
    input logic [CORDW-1:0] bp,
    output logic [CORDW-1:0] cnt,
    output logic wrap,
    output logic on,
    output logic syn
);
    localparam logic [CORDW:0] R_STA = {1'b0, I_ACT} + {1'b0, I_FP};
    localparam logic [CORDW:0] R_END = R_STA + {1'b0, I_SYNC};
    localparam logic [CORDW:0] R_LAST = R_END + {1'b0, I_BP} - (CORDW+1)'(1);
    logic [CORDW-1:0] b_act, b_last;
    logic [CORDW:0] b_sta, b_end, sta, fin, lst;
    assign sta = {1'b0, act} + {1'b0, fp};
    assign fin = sta + {1'b0, sync};
    assign lst = fin + {1'b0, bp} - (CORDW+1)'(1);
    assign wrap = cnt == b_last;
    assign on = cnt < b_act;
    assign syn = {1'b0, cnt} >= b_sta && {1'b0, cnt} < b_end;
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            b_act <= I_ACT;
            b_sta <= R_STA;
            b_end <= R_END;
            b_last <= R_LAST[CORDW-1:0];
            cnt <= '0;
        end else begin
            if (load) begin
                b_act <= act;
                b_sta <= sta;
                b_end <= fin;
                b_last <= lst[CORDW-1:0];
            end
            if (adv) cnt <= wrap ? '0 : cnt + CORDW'(1);
        end
endmodule

// File: rtl/video_timing_gen.sv
// video_timing_gen: runtime-reconfigurable raster timing; a validated mode waits
// in a one-deep pending slot and takes effect only at the end of a frame.
import video_timing_pkg::*;
module video_timing_gen #(
    parameter int CORDW = 12,
    parameter bit H_POL = 1'b1,
    parameter bit V_POL = 1'b1,
    parameter timing_t INIT = T_720P60
) (
    input logic clk_pix,
    input logic rst_pix,
    video_timing_gen_if.slave bus
);
    timing_t pend;
    logic [CORDW-1:0] hc, vc;
    logic h_wrap, v_wrap, h_on, v_on, h_syn, v_syn, take, ok, apply;
    assign take = bus.cfg_valid && bus.cfg_ready;
    assign ok = timing_ok(bus.cfg, CORDW);
    // cfg_ready low doubles as the pending-slot-full flag.
    assign apply = !bus.cfg_ready && h_wrap && v_wrap;
    timing_axis #(
        .CORDW(CORDW), .I_ACT(INIT.h_active[CORDW-1:0]), .I_FP(INIT.h_fp[CORDW-1:0]),
        .I_SYNC(INIT.h_sync[CORDW-1:0]), .I_BP(INIT.h_bp[CORDW-1:0])
    ) h_axis (
        .clk(clk_pix), .rst(rst_pix), .adv(1'b1), .load(apply),
        .act(pend.h_active[CORDW-1:0]), .fp(pend.h_fp[CORDW-1:0]),
        .sync(pend.h_sync[CORDW-1:0]), .bp(pend.h_bp[CORDW-1:0]),
        .cnt(hc), .wrap(h_wrap), .on(h_on), .syn(h_syn)
    );
    timing_axis #(
        .CORDW(CORDW), .I_ACT(INIT.v_active[CORDW-1:0]), .I_FP(INIT.v_fp[CORDW-1:0]),
        .I_SYNC(INIT.v_sync[CORDW-1:0]), .I_BP(INIT.v_bp[CORDW-1:0])
    ) v_axis (
        .clk(clk_pix), .rst(rst_pix), .adv(h_wrap), .load(apply),
        .act(pend.v_active[CORDW-1:0]), .fp(pend.v_fp[CORDW-1:0]),
        .sync(pend.v_sync[CORDW-1:0]), .bp(pend.v_bp[CORDW-1:0]),
        .cnt(vc), .wrap(v_wrap), .on(v_on), .syn(v_syn)
    );
    always_ff @(posedge clk_pix or posedge rst_pix)
        if (rst_pix) begin
            pend <= INIT;
            bus.cfg_ready <= 1'b1;
            bus.cfg_err <= 1'b0;
            bus.sx <= '0;
            bus.sy <= '0;
            bus.de <= 1'b0;
            bus.hsync <= !H_POL;
            bus.vsync <= !V_POL;
            bus.line_start <= 1'b0;
            bus.frame_start <= 1'b0;
        end else begin
            if (take && ok) pend <= bus.cfg;
            bus.cfg_ready <= apply ? 1'b1 : (take && ok) ? 1'b0 : bus.cfg_ready;
            bus.cfg_err <= take && !ok;
            bus.sx <= hc;
            bus.sy <= vc;
            bus.de <= h_on && v_on;
            bus.hsync <= H_POL ? h_syn : !h_syn;
            bus.vsync <= V_POL ? v_syn : !v_syn;
            bus.line_start <= hc == '0;
            bus.frame_start <= hc == '0 && vc == '0;
        end
endmodule

// File: tb/tb_video_timing_gen.sv
// tb_video_timing_gen: directed checks of raster timing, mode updates, rejects and reset.
import video_timing_pkg::*;
module tb_video_timing_gen;
    localparam timing_t T_A = '{12'd16, 12'd2, 12'd3, 12'd4, 12'd8, 12'd1, 12'd2, 12'd3};
    localparam timing_t T_B = '{12'd10, 12'd1, 12'd2, 12'd2, 12'd6, 12'd1, 12'd1, 12'd1};
    localparam timing_t T_C = '{12'd12, 12'd1, 12'd2, 12'd1, 12'd5, 12'd1, 12'd1, 12'd1};
    localparam timing_t T_D = '{12'd4000, 12'd32, 12'd32, 12'd32, 12'd2, 12'd1, 12'd1, 12'd1};
    localparam timing_t BAD_HA = '{12'd0, 12'd1, 12'd2, 12'd1, 12'd5, 12'd1, 12'd1, 12'd1};
    localparam timing_t BAD_VS = '{12'd12, 12'd1, 12'd2, 12'd1, 12'd5, 12'd1, 12'd0, 12'd1};
    localparam timing_t BAD_HT = '{12'd4000, 12'd50, 12'd40, 12'd20, 12'd5, 12'd1, 12'd1, 12'd1};
    logic clk_pix = 1'b0;
    logic rst_pix = 1'b1;
    int total = 0;
    int bad = 0;
    video_timing_gen_if #(.CORDW(12)) bus1 ();
    video_timing_gen_if #(.CORDW(12)) bus2 ();
    video_timing_gen_if #(.CORDW(12)) bus3 ();
    video_timing_gen #(.CORDW(12), .H_POL(1'b1), .V_POL(1'b1), .INIT(T_A)) dut1 (
        .clk_pix(clk_pix), .rst_pix(rst_pix), .bus(bus1));
    video_timing_gen #(.CORDW(12), .H_POL(1'b0), .V_POL(1'b0), .INIT(T_A)) dut2 (
        .clk_pix(clk_pix), .rst_pix(rst_pix), .bus(bus2));
    video_timing_gen #(.CORDW(12)) dut3 (
        .clk_pix(clk_pix), .rst_pix(rst_pix), .bus(bus3));
    always #5 clk_pix = ~clk_pix;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic offer(input timing_t t);
        bus1.cfg = t;
        bus1.cfg_valid = 1'b1;
        @(negedge clk_pix);
        bus1.cfg_valid = 1'b0;
    endtask

    task automatic wait_pos(input string tag, input int x, input int y);
        int n = 0;
        while (!(int'(bus1.sx) == x && int'(bus1.sy) == y) && n < 50000) begin
            @(negedge clk_pix);
            n++;
        end
        if (n >= 50000) check({tag, "_timeout"}, 0, 1);
    endtask

    // Waits for a frame start, then compares one whole frame against a raster model.
    task automatic frame_chk(input string tag, input timing_t t, input bit pol2);
        int ha, hf, hs, hb, va, vf, vs, vb, ht, vt, errs, n;
        bit hs_e, vs_e;
        ha = int'(t.h_active); hf = int'(t.h_fp); hs = int'(t.h_sync); hb = int'(t.h_bp);
        va = int'(t.v_active); vf = int'(t.v_fp); vs = int'(t.v_sync); vb = int'(t.v_bp);
        ht = ha + hf + hs + hb;
        vt = va + vf + vs + vb;
        errs = 0;
        n = 0;
        while (!bus1.frame_start && n < 50000) begin
            @(negedge clk_pix);
            n++;
        end
        if (n >= 50000) check({tag, "_timeout"}, 0, 1);
        for (int y = 0; y < vt; y++)
            for (int x = 0; x < ht; x++) begin
                hs_e = x >= ha + hf && x < ha + hf + hs;
                vs_e = y >= va + vf && y < va + vf + vs;
                if (int'(bus1.sx) != x || int'(bus1.sy) != y || bus1.de !== (x < ha && y < va) ||
                    bus1.hsync !== hs_e || bus1.vsync !== vs_e || bus1.line_start !== (x == 0) ||
                    bus1.frame_start !== (x == 0 && y == 0)) errs++;
                if (pol2 && (bus2.hsync !== !hs_e || bus2.vsync !== !vs_e)) errs++;
                @(negedge clk_pix);
            end
        check({tag, "_px"}, errs, 0);
        check({tag, "_fs"}, {bus1.frame_start, bus1.sx, bus1.sy}, {1'b1, 24'd0});
    endtask

    initial begin
        int de_n, hs_n, hs_lo, hs_hi, errs;
        bus1.cfg = T_A; bus1.cfg_valid = 1'b0;
        bus2.cfg = T_A; bus2.cfg_valid = 1'b0;
        bus3.cfg = T_A; bus3.cfg_valid = 1'b0;
        repeat (3) @(negedge clk_pix);
        check("rst_pos", {bus1.sx, bus1.sy}, 0);
        check("rst_de", bus1.de, 0);
        check("rst_sync_pos", {bus1.hsync, bus1.vsync}, 2'b00);
        check("rst_sync_neg", {bus2.hsync, bus2.vsync}, 2'b11);
        check("rst_strobes", {bus1.line_start, bus1.frame_start, bus1.cfg_err}, 3'b000);
        check("rst_ready", bus1.cfg_ready, 1);
        rst_pix = 1'b0;
        @(negedge clk_pix);
        check("first_pos", {bus1.sx, bus1.sy}, 0);
        check("first_flags", {bus1.de, bus1.line_start, bus1.frame_start}, 3'b111);
        check("first_720", {bus3.de, bus3.line_start, bus3.frame_start}, 3'b111);
        de_n = 0; hs_n = 0; hs_lo = -1; hs_hi = -1; errs = 0;
        for (int i = 0; i < 1650; i++) begin
            if (int'(bus3.sx) != i || bus3.sy != 0 || bus3.vsync) errs++;
            if (bus3.de) de_n++;
            if (bus3.hsync) begin
                hs_n++;
                if (hs_lo < 0) hs_lo = i;
                hs_hi = i;
            end
            @(negedge clk_pix);
        end
        check("l720_px", errs, 0);
        check("l720_de", de_n, 1280);
        check("l720_hs_n", hs_n, 40);
        check("l720_hs_lo", hs_lo, 1390);
        check("l720_hs_hi", hs_hi, 1429);
        check("l720_wrap", {bus3.line_start, bus3.sx, bus3.sy}, {1'b1, 12'd0, 12'd1});
        frame_chk("a0", T_A, 1'b1);
        wait_pos("mid", 3, 5);
        offer(T_B);
        check("take_ready", bus1.cfg_ready, 0);
        check("take_err", bus1.cfg_err, 0);
        bus1.cfg = T_C;
        bus1.cfg_valid = 1'b1;
        repeat (3) @(negedge clk_pix);
        bus1.cfg_valid = 1'b0;
        check("busy_ready", bus1.cfg_ready, 0);
        check("busy_err", bus1.cfg_err, 0);
        wait_pos("pre_apply", 23, 13);
        check("rdy_before", bus1.cfg_ready, 0);
        @(negedge clk_pix);
        check("rdy_after", {bus1.cfg_ready, bus1.sx, bus1.sy}, {1'b1, 12'd24, 12'd13});
        frame_chk("b", T_B, 1'b0);
        offer(T_C);
        check("c_take", {bus1.cfg_ready, bus1.cfg_err}, 2'b00);
        frame_chk("c", T_C, 1'b0);
        offer(BAD_HA);
        check("err_ha", {bus1.cfg_err, bus1.cfg_ready}, 2'b11);
        @(negedge clk_pix);
        check("err_pulse", bus1.cfg_err, 0);
        offer(BAD_VS);
        check("err_vs", {bus1.cfg_err, bus1.cfg_ready}, 2'b11);
        @(negedge clk_pix);
        offer(BAD_HT);
        check("err_ht", {bus1.cfg_err, bus1.cfg_ready}, 2'b11);
        @(negedge clk_pix);
        frame_chk("c2", T_C, 1'b0);
        offer(T_D);
        check("ht_max_take", {bus1.cfg_err, bus1.cfg_ready}, 2'b00);
        wait_pos("pre_rst", 5, 3);
        #2 rst_pix = 1'b1;
        #1;
        check("arst_pos", {bus1.sx, bus1.sy}, 0);
        check("arst_flags", {bus1.de, bus1.frame_start, bus1.cfg_ready}, 3'b001);
        @(negedge clk_pix);
        rst_pix = 1'b0;
        frame_chk("a1", T_A, 1'b1);
        frame_chk("a2", T_A, 1'b1);
        check("end_ready", bus1.cfg_ready, 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/video_timing_gen.md
# video_timing_gen

Parametrised, runtime-reconfigurable video timing generator. It replaces fixed-mode timing blocks in the HDMI/VGA pixel pipeline. It produces the screen coordinates, sync, data-enable and line/frame start strobes for any mode that fits `CORDW` bits. A new mode is accepted through a valid/ready handshake and applied only at a frame boundary, so no partial or torn frames are ever emitted.

## Interface
- `CORDW`, 12: coordinate and counter width; also the width of every timing field.
- `H_POL`, 1: hsync active level (1 = positive, 0 = negative).
- `V_POL`, 1: vsync active level.
- `INIT`, `video_timing_pkg::T_720P60`: timing in force after reset.

- `clk_pix`  in  1  pixel clock.
- `rst_pix`  in  1  reset: asynchronous, active-high. The clock is `clk_pix`.
- `cfg`  in  `timing_t`  new timing: `{h_active, h_fp, h_sync, h_bp, v_active, v_fp, v_sync, v_bp}`, each field `CORDW` bits.
- `cfg_valid`  in  1  `cfg` is offered.
- `cfg_ready`  out  1  pending slot is empty.
- `cfg_err`  out  1  one-cycle pulse when an offered config is rejected.
- `sx`, `sy`  out  `CORDW`  current pixel and line position.
- `hsync`, `vsync`  out  1  sync outputs, at the polarity set by `H_POL`/`V_POL`.
- `de`  out  1  pixel is in the active region.
- `line_start`  out  1  high when `sx`==0.
- `frame_start`  out  1  high when `sx`==0 and `sy`==0.

## Operation
- Internal counters `hc` and `vc` run 0..HT-1 and 0..VT-1, where HT = h_active+h_fp+h_sync+h_bp and VT is the vertical equivalent.
- `hc` increments every cycle. When `hc`==HT-1, `hc` wraps to 0 and `vc` increments. When `vc`==VT-1 at that same point, `vc` wraps to 0 as well.
- Decodes, evaluated on `hc`/`vc`:
  - `de` = hc<h_active and vc<v_active.
  - hsync is active for h_active+h_fp ≤ hc < h_active+h_fp+h_sync.
  - vsync uses the same rule on `vc` with the vertical fields.
- Region boundaries HS_STA, HS_END, HT-1 and the vertical equivalents are precomputed into registers whenever a config is applied. They are computed with `CORDW`+1-bit sums.
- Config path:
  - When `cfg_valid` and `cfg_ready` are both high, the config is validated.
  - If it is valid, it is stored in the pending register and `cfg_ready` falls.
  - A config is rejected when h_active, v_active, h_sync or v_sync is 0, or when HT or VT exceeds 2^`CORDW`.
  - On rejection, `cfg_err` pulses for one cycle, nothing is stored, and `cfg_ready` stays high.
- Apply: on the cycle where hc==HT-1 and vc==VT-1 with the pending slot full, the pending config becomes active and the slot empties.
  - The new frame starts at count 0 under the new timing.
  - `cfg_ready` rises on the next cycle.
- Simultaneous events: if a capture and the frame end fall on the same edge, the captured config is applied at the following frame end.
- Reset mid-frame: counters go to 0, the active timing returns to `INIT`, and any pending config is discarded.

## Timing
- All outputs are registered. `sx`, `sy`, `hsync`, `vsync`, `de`, `line_start` and `frame_start` are decoded from the same `hc`/`vc` value and registered together. They therefore lag the counters by exactly 1 cycle and are mutually aligned.
- Reset values:
  - `sx`=0, `sy`=0, `de`=0.
  - `hsync`=!`H_POL`, `vsync`=!`V_POL`.
  - `line_start`=0, `frame_start`=0, `cfg_err`=0.
  - `cfg_ready`=1.
- First clock edge after reset release: `sx`=0, `sy`=0, `de`=1, `line_start`=1, `frame_start`=1.
- `cfg_err` is asserted in the cycle after the offending handshake.
- Handshake-to-apply latency is at most one full frame plus 1 cycle.

## Structure
- Package `video_timing_pkg` holds:
  - `typedef struct packed timing_t`, parameterised by a package-level `CORDW_MAX` of 12.
  - Preset constants `T_640X480P60`, `T_720P60` and `T_1080P30`.
  - Function `timing_ok(timing_t)`, which is shared with the bench.
- One sub-module, `timing_axis`, instantiated twice (horizontal and vertical).
  - It contains the counter, the boundary registers and the sync/active decode.
  - It has an advance enable and a wrap output.

## Test plan
- Reset with `INIT`=720p → 1650 cycles per line and 750 lines per frame; `hsync`=1 for `sx` 1390..1429; `vsync`=1 for `sy` 725..729; `de` count per frame = 921600.
- Mid-frame offer of `T_640X480P60` at `sy`=300 → the current frame completes at 750 lines; the next frame has 800×525 timing with `frame_start` at its first pixel; `cfg_ready` low from the handshake until 1 cycle after the apply.
- Offer with h_active=0 → `cfg_err` pulses once; `cfg_ready` stays 1; timing unchanged.
- Second offer while `cfg_ready`=0 → not captured; the first config is applied; the second is accepted only after `cfg_ready` rises.
- `H_POL`=0, `V_POL`=0 → sync outputs idle high and low during the sync windows; reset value of both is 1.
- `rst_pix` asserted at `sx`=500, `sy`=100 with a config pending → asynchronous clear; the pending config is dropped and the following frame uses `INIT`.
